// File: rtl/music_play_ctrl.sv
// music_play_ctrl: playback sequencer for the KeyTunePlayer note RAM.
//
// Walks the song from address 0 to music_len-1. Each entry is fetched from a
// synchronous (1-cycle latency) note RAM and held on the tone-generator
// interface for (dur+1)*BEAT_TICKS cycles. play_key toggles play/pause and
// stop_key aborts to idle.
//
// Optional feature: define MUSIC_LOOP_EN to restart the song from address 0
// at song end instead of returning to idle.
//
// Parameters:
//   BEAT_TICKS   sys_clk cycles per duration unit (>= 2)
//   ADDR_W       note RAM address width
//
// Ports:
//   sys_clk       system clock
//   sys_rst_n     asynchronous active-low reset
//   play_key      one-cycle pulse, play/pause toggle
//   stop_key      one-cycle pulse, abort to idle
//   music_len     number of note entries in the song (compared live)
//   ram_rdata     note entry: [7:3] note code (0 = rest), [2:0] units minus 1
//   ram_addr_out  note RAM read address, also drives the progress display
//   note          current note code to the tone generator
//   note_valid    high while a note or rest is timed in PLAY
//   playing       high in FETCH, WAIT and PLAY
//   song_done     one-cycle pulse when the last entry finishes
module music_play_ctrl #(
  parameter int unsigned BEAT_TICKS = 12_500_000,
  parameter int unsigned ADDR_W     = 12
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              play_key,
  input  logic              stop_key,
  input  logic [ADDR_W-1:0] music_len,
  input  logic [7:0]        ram_rdata,
  output logic [ADDR_W-1:0] ram_addr_out,
  output logic [4:0]        note,
  output logic              note_valid,
  output logic              playing,
  output logic              song_done
);

  localparam int unsigned TickW = $clog2(BEAT_TICKS);

  localparam logic [TickW-1:0]  TickReload = TickW'(BEAT_TICKS - 1);
  localparam logic [TickW-1:0]  TickOne    = TickW'(1);
  localparam logic [ADDR_W-1:0] AddrOne    = ADDR_W'(1);
  localparam logic [ADDR_W:0]   AddrOneX   = (ADDR_W + 1)'(1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StFetch = 3'd1;
  localparam logic [2:0] StWait  = 3'd2;
  localparam logic [2:0] StPlay  = 3'd3;
  localparam logic [2:0] StPause = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [4:0]        note_q, note_d;
  logic              note_valid_q, note_valid_d;
  logic              playing_q, playing_d;
  logic              done_q, done_d;
  logic [TickW-1:0]  tick_q, tick_d;
  logic [3:0]        unit_q, unit_d;

  logic note_expire;
  logic song_end;

  // Final cycle of the final unit of the current note.
  assign note_expire = (tick_q == '0) && (unit_q == 4'd1);

  // Compared one bit wider so addr+1 can never wrap and falsely pass; a
  // music_len that shrank below addr+1 ends the song at this note.
  assign song_end = (({1'b0, addr_q} + AddrOneX) >= {1'b0, music_len});

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    note_d  = note_q;
    tick_d  = tick_q;
    unit_d  = unit_q;
    done_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (play_key && (music_len != '0)) begin
          state_d = StFetch;
        end
      end

      // Address was presented last cycle; data arrives next cycle.
      StFetch: begin
        state_d = StWait;
      end

      StWait: begin
        note_d  = ram_rdata[7:3];
        unit_d  = {1'b0, ram_rdata[2:0]} + 4'd1;
        tick_d  = TickReload;
        state_d = StPlay;
      end

      StPlay: begin
        if (note_expire) begin
          // Expiry wins over a simultaneous pause request: the note is over.
          if (song_end) begin
            done_d = 1'b1;
            addr_d = '0;
`ifdef MUSIC_LOOP_EN
            state_d = StFetch;
`else
            note_d  = '0;
            tick_d  = '0;
            unit_d  = '0;
            state_d = StIdle;
`endif
          end else begin
            addr_d  = addr_q + AddrOne;
            state_d = StFetch;
          end
        end else begin
          // The cycle on which pause is requested still counts as played.
          if (tick_q == '0) begin
            tick_d = TickReload;
            unit_d = unit_q - 4'd1;
          end else begin
            tick_d = tick_q - TickOne;
          end
          if (play_key) begin
            state_d = StPause;
          end
        end
      end

      StPause: begin
        if (play_key) begin
          state_d = StPlay;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Stop overrides play/pause and note expiry.
    if (stop_key && (state_q != StIdle)) begin
      state_d = StIdle;
      addr_d  = '0;
      note_d  = '0;
      tick_d  = '0;
      unit_d  = '0;
      done_d  = 1'b0;
    end

    note_valid_d = (state_d == StPlay);
    playing_d    = (state_d == StFetch) || (state_d == StWait) || (state_d == StPlay);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      note_q       <= '0;
      note_valid_q <= 1'b0;
      playing_q    <= 1'b0;
      done_q       <= 1'b0;
      tick_q       <= '0;
      unit_q       <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      note_q       <= note_d;
      note_valid_q <= note_valid_d;
      playing_q    <= playing_d;
      done_q       <= done_d;
      tick_q       <= tick_d;
      unit_q       <= unit_d;
    end
  end

  assign ram_addr_out = addr_q;
  assign note         = note_q;
  assign note_valid   = note_valid_q;
  assign playing      = playing_q;
  assign song_done    = done_q;

endmodule

// File: doc/music_play_ctrl.md
# music_play_ctrl

Playback sequencer for the KeyTunePlayer note RAM. It walks the song from address 0 to `music_len-1` and fetches one note entry per step. Each note is held on the tone-generator interface for its encoded duration. It drives `ram_addr_out`, which feeds the progress-bar display, and handles play/pause/stop key pulses.

## Interface
Parameters:
- `BEAT_TICKS`, default 12_500_000: sys_clk cycles per duration unit (125 ms at 100 MHz); must be ≥ 2.
- `ADDR_W`, default 12: note RAM address width.

Ports:
- `sys_clk`  in  1  system clock, 100 MHz.
- `sys_rst_n`  in  1  reset; asynchronous, active-low.
- `play_key`  in  1  one-cycle pulse, debounced upstream; play/pause toggle.
- `stop_key`  in  1  one-cycle pulse; abort to idle.
- `music_len`  in  ADDR_W  number of note entries in the song.
- `ram_rdata`  in  8  note entry: [7:3] note code (0 = rest), [2:0] duration units minus 1.
- `ram_addr_out`  out  ADDR_W  note RAM read address; also feeds the progress display.
- `note`  out  5  current note code to the tone generator.
- `note_valid`  out  1  high while a note or rest is being timed in PLAY.
- `playing`  out  1  high in FETCH, WAIT and PLAY.
- `song_done`  out  1  one-cycle pulse when the last entry finishes.

## Operation
- Note RAM is synchronous with 1-cycle read latency. `ram_rdata` is valid the cycle after `ram_addr_out` changes.
- States: IDLE, FETCH, WAIT, PLAY, PAUSE.
- IDLE:
  - Outputs: `ram_addr_out`=0, `note`=0, `note_valid`=0.
  - `play_key` with `music_len`≠0 → FETCH.
  - `play_key` with `music_len`=0 is ignored.
- FETCH: address is stable. Unconditionally → WAIT.
- WAIT:
  - Latch `note`=`ram_rdata[7:3]`.
  - Load unit counter = `ram_rdata[2:0]`+1 (range 1..8).
  - Load tick counter = BEAT_TICKS-1.
  - → PLAY.
- PLAY:
  - `note_valid`=1. Tick counter decrements each cycle.
  - At tick 0: reload the tick counter and decrement the unit counter.
  - When the last unit expires and `ram_addr_out`+1 ≥ `music_len`: pulse `song_done`, go to end-of-song handling (see Configuration).
  - When the last unit expires otherwise: `ram_addr_out`+1, → FETCH.
- PAUSE (entered by `play_key` in PLAY):
  - Both counters and `note` are frozen; `note_valid`=0, `playing`=0.
  - `play_key` → PLAY, resuming the remaining time exactly.
- `stop_key` in any non-IDLE state → IDLE. It has priority over `play_key` in the same cycle and over note expiry.
- `play_key` in FETCH or WAIT is ignored; pausing is only possible from PLAY.
- `music_len` is compared live at each note end. If it shrinks below the current address+1, the song ends at that note.
- Address arithmetic is ADDR_W-bit. The ≥ compare guarantees no wrap past `music_len`-1.

## Timing
- All outputs are registered.
- Reset values: `ram_addr_out`=0, `note`=0, `note_valid`=0, `playing`=0, `song_done`=0, state=IDLE, counters=0.
- `play_key` at cycle 0 from IDLE:
  - FETCH at cycle 1, WAIT at cycle 2.
  - `note`/`note_valid` valid from cycle 3.
- A note lasts exactly (dur+1)×BEAT_TICKS cycles in PLAY.
- Inter-note gap: 2 cycles (FETCH and WAIT) with `note_valid`=0.
- Pause/resume has no lost or added PLAY cycles.
- `song_done` is asserted for exactly the one cycle after the final PLAY cycle, concurrent with the state leaving PLAY.
- Reset asserted mid-operation clears everything immediately. Reset release returns to IDLE.

## Configuration
- `MUSIC_LOOP_EN` defined: at song end, `song_done` pulses, `ram_addr_out` wraps to 0 and the state goes to FETCH. Playback repeats until `stop_key`.
- Not defined: at song end, `song_done` pulses, `ram_addr_out`=0, state → IDLE.

## Test plan
- BEAT_TICKS=4, `music_len`=3, RAM = {0x0A:code1,dur2 / 0x10:code2,dur0 / 0x1F:code3,dur7}. `play_key` → notes 1,2,3 for 12, 4 and 32 PLAY cycles, each separated by 2-cycle gaps. `song_done` single pulse, then IDLE with addr 0.
- Same song, `play_key` at PLAY cycle 5 of note 1, again 20 cycles later. `note_valid` low for 20 cycles, note 1 then plays its remaining 7 cycles.
- `stop_key` and `play_key` asserted together in PLAY → IDLE next cycle, `note_valid`=0, addr 0, no `song_done`.
- `music_len`=0 with `play_key` → remains IDLE, all outputs at reset values.
- `music_len` changed from 3 to 1 during note 1 → `song_done` at the end of note 1, addr 0.
- With `MUSIC_LOOP_EN`, `music_len`=2 → after note 2, `song_done` pulses and FETCH of addr 0 follows; after a second pass, `stop_key` → IDLE.
